// File: rtl/mul_result_sequencer_pkg.sv
// Shared types and widths for the multiplier result sequencer.
// Optional feature macro: MUL_SEQ_OVF_EN (32-bit signed overflow flag).
package mul_seq_pkg;

  localparam int MUL_WORD_W   = 32;
  localparam int MUL_PROD_W   = 64;
  localparam int SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } mul_seq_state_t;

  // True when the signed 64-bit product cannot be represented in 32 signed bits.
  function automatic logic prod_ovf(input logic [MUL_PROD_W-1:0] p);
    return p[MUL_PROD_W-1:MUL_WORD_W] != {MUL_WORD_W{p[MUL_WORD_W-1]}};
  endfunction

endpackage

// File: rtl/mul_result_sequencer_if.sv
// Output word stream of the result sequencer (LO word first, then HI word).
// Handshake: a word transfers on a rising edge where out_valid && out_ready;
// while out_valid=1 and out_ready=0 the producer holds out_data/out_is_hi/ovf.
interface mul_result_sequencer_if;
  import mul_seq_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [MUL_WORD_W-1:0] out_data;
  logic                  out_is_hi;
  logic                  ovf;

  modport master (
    output out_valid,
    output out_data,
    output out_is_hi,
    output ovf,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_is_hi,
    input  ovf,
    output out_ready
  );

endinterface

// File: rtl/mul_result_sequencer_settle_timer.sv
// Down-counter timing the multiplier settle window; flags when it reaches zero.
module settle_timer
  import mul_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SETTLE_CNT_W-1:0] load_val,
  input  logic                    load_en,
  input  logic                    dec_en,
  output logic                    cnt_zero
);

  logic [SETTLE_CNT_W-1:0] cnt;

  // Load has priority; decrement never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load_en) begin
      cnt <= load_val;
    end else if (dec_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/mul_result_sequencer.sv
// Waits out the multiplier settle window, captures the 64-bit product and
// streams it as LO then HI words. Optional macro: MUL_SEQ_OVF_EN.
module mul_result_sequencer
  import mul_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MUL_PROD_W-1:0]   product,
  output logic                    busy,
  mul_result_sequencer_if.master  out,
  output mul_seq_state_t          dbg_state
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  mul_seq_state_t          state_q, state_d;
  logic [MUL_PROD_W-1:0]   z_reg;
  logic                    ovf_q;
  logic                    load_en;
  logic                    dec_en;
  logic                    capture;
  logic                    done_hi;
  logic                    cnt_zero;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load_val (SETTLE_LOAD),
    .load_en  (load_en),
    .dec_en   (dec_en),
    .cnt_zero (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    load_en       = 1'b0;
    dec_en        = 1'b0;
    capture       = 1'b0;
    done_hi       = 1'b0;
    busy          = 1'b1;
    out.out_valid = 1'b0;
    out.out_data  = '0;
    out.out_is_hi = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load_en = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = SEND_LO;
        end else begin
          dec_en = 1'b1;
        end
      end
      SEND_LO: begin
        out.out_valid = 1'b1;
        out.out_data  = z_reg[MUL_WORD_W-1:0];
        if (out.out_ready) begin
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        out.out_valid = 1'b1;
        out.out_data  = z_reg[MUL_PROD_W-1:MUL_WORD_W];
        out.out_is_hi = 1'b1;
        if (out.out_ready) begin
          done_hi = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // z_reg is written only at capture; the product input is ignored otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_reg <= '0;
    end else if (capture) begin
      z_reg <= product;
    end
  end

`ifdef MUL_SEQ_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (capture) begin
      ovf_q <= prod_ovf(product);
    end else if (done_hi) begin
      ovf_q <= 1'b0;
    end
  end
`else
  assign ovf_q = 1'b0;
`endif

  assign out.ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_result_sequencer.sv
// Directed bench for mul_result_sequencer with a scoreboard of expected words.
module tb_mul_result_sequencer;
  import mul_seq_pkg::*;

  localparam int S = 2;
  localparam int W = 34;  // {ovf, is_hi, data}

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [MUL_PROD_W-1:0] product;
  logic                  busy;
  mul_seq_state_t        dbg_state;

  mul_result_sequencer_if bus ();

  mul_result_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .product   (product),
    .busy      (busy),
    .out       (bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_words = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic [63:0] p);
`ifdef MUL_SEQ_OVF_EN
    return ($signed(p) > 64'sh000000007FFFFFFF) || ($signed(p) < -64'sh0000000080000000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void push_words(input logic [63:0] p);
    exp_q.push_back({exp_ovf(p), 1'b0, p[31:0]});
    exp_q.push_back({exp_ovf(p), 1'b1, p[63:32]});
  endfunction

  // scoreboard: a word is accepted on an edge with valid && ready && !rst
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready && !rst) begin
      logic [W-1:0] e;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_word observed=%h expected=none", bus.out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_words++;
        check("word", {30'd0, bus.ovf, bus.out_is_hi, bus.out_data}, {30'd0, e});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [63:0] p);
    product = p;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_data"}, 64'(bus.out_data), 64'd0);
    check({tag, "_is_hi"}, 64'(bus.out_is_hi), 64'd0);
    check({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("idle_timeout", 64'(busy), 64'd0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] held_data;
    logic        held_hi;
    logic [63:0] p;

    rst = 1'b0;
    start = 1'b0;
    product = '0;
    bus.out_ready = 1'b1;
    do_reset();
    check_idle_outputs("reset");

    // basic: timing of out_valid, LO then HI, busy drop at S+2 edges
    push_words(64'd150);
    pulse_start(64'd150);
    check("settle_busy", 64'(busy), 64'd1);
    for (int i = 1; i < S; i++) begin
      check("settle_valid", 64'(bus.out_valid), 64'd0);
      tick();
    end
    check("settle_valid_last", 64'(bus.out_valid), 64'd0);
    tick();
    check("lo_valid", 64'(bus.out_valid), 64'd1);
    check("lo_data", 64'(bus.out_data), 64'h96);
    check("lo_is_hi", 64'(bus.out_is_hi), 64'd0);
    tick();
    check("hi_data", 64'(bus.out_data), 64'h0);
    check("hi_is_hi", 64'(bus.out_is_hi), 64'd1);
    tick();
    check("basic_busy_fall", 64'(busy), 64'd0);

    // negative product, started the cycle right after the HI handshake
    p = -64'sd150;
    push_words(p);
    pulse_start(p);
    tick();
    tick();
    check("neg_lo", 64'(bus.out_data), 64'hFFFFFF6A);
    tick();
    check("neg_hi", 64'(bus.out_data), 64'hFFFFFFFF);
    wait_idle(20, 1'b0);

    // overflow
    p = 64'h3FFFFFFF00000001;
    push_words(p);
    pulse_start(p);
    tick();
    tick();
    check("ovf_lo", 64'(bus.out_data), 64'h1);
`ifdef MUL_SEQ_OVF_EN
    check("ovf_flag_lo", 64'(bus.ovf), 64'd1);
`else
    check("ovf_flag_lo", 64'(bus.ovf), 64'd0);
`endif
    tick();
    check("ovf_hi", 64'(bus.out_data), 64'h3FFFFFFF);
    wait_idle(20, 1'b0);
    check("ovf_cleared", 64'(bus.ovf), 64'd0);

    // back-pressure: 3 cycles on LO, 2 on HI
    p = {$urandom, $urandom};
    push_words(p);
    bus.out_ready = 1'b0;
    pulse_start(p);
    tick();
    tick();
    held_data = bus.out_data;
    held_hi   = bus.out_is_hi;
    check("bp_lo_first", 64'(held_data), 64'(p[31:0]));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_lo_data", 64'(bus.out_data), 64'(held_data));
      check("bp_lo_is_hi", 64'(bus.out_is_hi), 64'(held_hi));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    held_data = bus.out_data;
    check("bp_hi_first", 64'(held_data), 64'(p[63:32]));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_hi_data", 64'(bus.out_data), 64'(held_data));
      check("bp_hi_is_hi", 64'(bus.out_is_hi), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_done", 64'(busy), 64'd0);

    // ignored start in SETTLE and SEND_LO, product changed after capture
    p = 64'h0123456789ABCDEF;
    push_words(p);
    bus.out_ready = 1'b0;
    pulse_start(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    product = 64'hDEADBEEFCAFEF00D;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_lo", 64'(bus.out_data), 64'h89ABCDEF);
    bus.out_ready = 1'b1;
    tick();
    check("ign_hi", 64'(bus.out_data), 64'h01234567);
    tick();
    check("ign_idle", 64'(busy), 64'd0);
    tick();
    check("ign_no_queue", 64'(busy), 64'd0);

    // reset in SETTLE
    pulse_start(64'h5555);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_settle");
    for (int i = 0; i < S + 2; i++) tick();
    check("rst_settle_quiet", 64'(bus.out_valid), 64'd0);

    // reset coincident with the LO handshake
    bus.out_ready = 1'b0;
    pulse_start(64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    tick();
    check("rst_lo_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rst_lo");
    tick();
    check("rst_lo_no_hi", 64'(bus.out_valid), 64'd0);

    // recovery after reset
    p = 64'h0000000700000009;
    push_words(p);
    pulse_start(p);
    wait_idle(20, 1'b0);

    // random products under random back-pressure
    for (int t = 0; t < 6; t++) begin
      p = {$urandom, $urandom};
      if (t == 0) p = 64'hFFFFFFFF80000000;
      if (t == 1) p = 64'h0000000080000000;
      push_words(p);
      pulse_start(p);
      wait_idle(200, 1'b1);
    end

    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("word_count", 64'(n_words), 64'd24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_result_sequencer.md
# mul_result_sequencer

Downstream consumer of the combinational 32x32 signed Booth/CSA multiplier. It times the multiplier's multicycle settle window after operands are applied, captures the 64-bit product into an internal Z register, and streams it onto the 32-bit datapath as two words (LO, then HI) under a valid/ready handshake. It is the only path by which a product reaches the HI/LO registers or the bus.

## Interface
- `SETTLE_CYCLES`, default 2: clock edges between `start` and product capture. Legal range is 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset: one clock, synchronous, active-high.
- `start`  in  1  multiplier operands are applied this cycle. Upstream holds them stable while `busy` is 1.
- `product`  in  64  signed product from the multiplier.
- `busy`  out  1  high in every state except IDLE. Doubles as the operand-hold request.
- `out_valid`  out  1  `out_data` carries a word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  32  current word; 0 when `out_valid`=0.
- `out_is_hi`  out  1  0 for the LO word, 1 for the HI word.
- `ovf`  out  1  product does not fit in 32 signed bits. Meaningful while `out_valid`=1.

## Operation
- FSM states: IDLE, SETTLE, SEND_LO, SEND_HI.
- IDLE, `start`=1: load `cnt` = SETTLE_CYCLES-1 and go to SETTLE. With `start`=0, stay in IDLE.
- SETTLE, `cnt`≠0: decrement `cnt`.
- SETTLE, `cnt`=0: capture `z_reg` <= `product` (and `ovf`), then go to SEND_LO.
- SEND_LO: `out_valid`=1, `out_data`=`z_reg[31:0]`, `out_is_hi`=0. On `out_valid`&&`out_ready`, go to SEND_HI.
- SEND_HI: `out_valid`=1, `out_data`=`z_reg[63:32]`, `out_is_hi`=1. On handshake, go to IDLE.
- `start` in any non-IDLE state is ignored. No queuing, no error.
- `z_reg` changes only at capture and at reset. The product is never re-sampled during SEND_*.
- Arithmetic: none. The product is passed bit-exact; sign is already encoded by the multiplier.

## Timing
- `start` sampled at edge t0 leads to capture at edge t0+SETTLE_CYCLES. `out_valid` rises after that same edge.
- LO is offered first. HI follows on the cycle after the LO handshake at the earliest.
- Minimum `start` to IDLE: SETTLE_CYCLES+2 edges, with `out_ready` tied high.
- Back-pressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_is_hi` and `ovf` hold stable.
- `start` may be accepted on the cycle after the HI handshake, since the state is IDLE at that point.
- Reset values:
  - state IDLE, `cnt`=0, `z_reg`=0.
  - `busy`=0, `out_valid`=0, `out_data`=0, `out_is_hi`=0, `ovf`=0.
- Reset mid-operation (any state) discards the product with no partial output. `rst` wins over `start` and over a handshake in the same cycle.

## Configuration
- `MUL_SEQ_OVF_EN` defined:
  - `ovf` is registered at capture as (`product[63:32]` ≠ {32{`product[31]`}}).
  - It holds through SEND_LO and SEND_HI and is cleared on return to IDLE.
- `MUL_SEQ_OVF_EN` undefined: `ovf` is tied to 0 and no compare logic is built. The port list is identical in both builds.

## Structure
- Shared package `mul_seq_pkg` contains:
  - the state enum `mul_seq_state_t` (IDLE, SETTLE, SEND_LO, SEND_HI);
  - `MUL_WORD_W` = 32 and `MUL_PROD_W` = 64;
  - `SETTLE_CNT_W` = 4.
- One sub-module, `settle_timer`:
  - inputs: load value, load enable, decrement enable;
  - output: `cnt`=0 flag.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
- Basic LO/HI transfer:
  - stimulus: `product`=150 (15x10), `start` pulse, `out_ready`=1, SETTLE_CYCLES=2;
  - response: `out_valid` rises 2 edges after `start`; LO=0x00000096 with `out_is_hi`=0, then HI=0x00000000 with `out_is_hi`=1; `ovf`=0; `busy` falls after the HI handshake.
- Negative product:
  - stimulus: `product`=-150;
  - response: LO=0xFFFFFF6A, HI=0xFFFFFFFF, `ovf`=0.
- Overflow flag:
  - stimulus: `product`=0x3FFFFFFF00000001 (0x7FFFFFFF squared);
  - response: LO=0x00000001, HI=0x3FFFFFFF; `ovf`=1 with the macro defined, 0 without it.
- Back-pressure:
  - stimulus: hold `out_ready`=0 for 3 cycles in SEND_LO, then for 2 cycles in SEND_HI;
  - response: `out_data` and `out_is_hi` stable throughout; each word is accepted exactly once.
- Ignored `start`:
  - stimulus: `start` pulsed in SETTLE and again in SEND_LO, with `product` changed after capture;
  - response: the sequence is unaffected and the originally captured value is output.
- Reset mid-operation:
  - stimulus: `rst` in SETTLE, and separately `rst` coincident with the LO handshake;
  - response: state IDLE on the next edge, all outputs 0, no HI word emitted; the next `start` completes normally.
